// File: rtl/coin_acceptor.sv
// Coin acceptor front end. It synchronizes and debounces two coin sensors
// and rejects simultaneous hits as jams. Accepted coins are queued and issued
// as single-cycle codes, with forced idle gaps between codes.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin5_raw,
  input  logic                          coin10_raw,
  input  logic                          accept_en,
  output logic [1:0]                    coin,
  output logic                          coin_return,
  output logic                          jam,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] DbLast  = CW'(DEBOUNCE_CYCLES);
  localparam logic [GW-1:0] GapLast = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  // Bit 0 is the 5-unit line, bit 1 the 10-unit line, so a single event
  // vector doubles as the coin code.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q, db_q, db_prev_q, ev_q;
  logic [CW-1:0] cnt_q [2];

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [1:0]  mem_q [FIFO_DEPTH];
  logic [1:0]  head;
  logic        empty, full, push_req, push, pop, drop, jam_now;

  state_e      state_q;
  logic [GW-1:0] gcnt_q;

  assign raw = {coin10_raw, coin5_raw};

  // Two-flop synchronizers, per-line debounce and rising-edge events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      ev_q      <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      ev_q      <= db_q & ~db_prev_q;
      for (int i = 0; i < 2; i++) begin
        // cnt holds the number of differing cycles already seen; db flips
        // once that reaches DEBOUNCE_CYCLES and the line still differs.
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DbLast) begin
          db_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // FIFO status, push/drop/jam decode and pop request from the output FSM.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    jam_now  = &ev_q;
    push_req = ^ev_q;
    pop      = ((state_q == StIdle) || ((state_q == StGap) && (gcnt_q == GapLast)))
               && !empty && accept_en;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    drop     = push_req && full && !pop;
    push     = push_req && !drop;
  end

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_count = wr_ptr_q - rd_ptr_q;

  // Coin storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= ev_q;
    end
  end

  // Queue pointers with an extra wrap bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Return and jam pulses, aligned with the cycle the push would have landed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_return <= 1'b0;
      jam         <= 1'b0;
    end else begin
      coin_return <= jam_now || drop;
      jam         <= jam_now;
    end
  end

  // Output FSM: issue one code, then hold GAP_CYCLES idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gcnt_q  <= '0;
      coin    <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          coin <= 2'b00;
          if (pop) begin
            coin    <= head;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          coin    <= 2'b00;
          gcnt_q  <= '0;
          state_q <= StGap;
        end
        StGap: begin
          coin <= 2'b00;
          // The last gap cycle also performs the idle pop test.
          if (gcnt_q == GapLast) begin
            if (pop) begin
              coin    <= head;
              state_q <= StIssue;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: begin
          coin    <= 2'b00;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor with default parameters.
module tb_coin_acceptor;

  logic       clk;
  logic       rst;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       accept_en;
  logic [1:0] coin;
  logic       coin_return;
  logic       jam;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor state, only ever written by the monitor processes.
  int cyc = 0;
  int n_ret = 0;
  int n_jam = 0;
  int n_misalign = 0;
  int n_fifo_nz = 0;
  int n_bad_code = 0;
  int coin_cyc_q[$];
  int coin_val_q[$];

  coin_acceptor dut (
    .clk         (clk),
    .rst         (rst),
    .coin5_raw   (coin5_raw),
    .coin10_raw  (coin10_raw),
    .accept_en   (accept_en),
    .coin        (coin),
    .coin_return (coin_return),
    .jam         (jam),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (coin != 2'b00) begin
      coin_cyc_q.push_back(cyc);
      coin_val_q.push_back(int'(coin));
    end
    if (coin == 2'b11) n_bad_code = n_bad_code + 1;
    if (coin_return) n_ret = n_ret + 1;
    if (jam) n_jam = n_jam + 1;
    if (jam && !coin_return) n_misalign = n_misalign + 1;
    if (fifo_count != 3'd0) n_fifo_nz = n_fifo_nz + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp = n_cmp + 1;
    if (got != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One isolated 5-unit coin: high 8 cycles, low 8 cycles.
  task automatic insert5();
    coin5_raw = 1'b1;
    cycles(8);
    coin5_raw = 1'b0;
    cycles(8);
  endtask

  int e0;
  int base;
  int ret0;
  int jam0;
  int nz0;

  initial begin
    rst        = 1'b0;
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    accept_en  = 1'b1;
    #1;
    check("rst_coin", int'(coin), 0);
    check("rst_return", int'(coin_return), 0);
    check("rst_jam", int'(jam), 0);
    check("rst_count", int'(fifo_count), 0);
    cycles(3);
    rst = 1'b1;
    cycles(3);

    // 1: clean 10-unit coin, code after edge 9.
    base = coin_cyc_q.size();
    ret0 = n_ret;
    coin10_raw = 1'b1;
    cycles(8);
    check("t1_e7_count", int'(fifo_count), 0);
    check("t1_e7_coin", int'(coin), 0);
    cycles(1);
    check("t1_e8_count", int'(fifo_count), 1);
    check("t1_e8_coin", int'(coin), 0);
    cycles(1);
    check("t1_e9_coin", int'(coin), 2);
    check("t1_e9_count", int'(fifo_count), 0);
    cycles(1);
    check("t1_e10_coin", int'(coin), 0);
    cycles(2);
    coin10_raw = 1'b0;
    cycles(20);
    check("t1_ncoin", coin_cyc_q.size() - base, 1);
    check("t1_return", n_ret - ret0, 0);

    // 2: bounce, latency from start of final high run.
    base = coin_cyc_q.size();
    coin5_raw = 1'b1;
    cycles(2);
    coin5_raw = 1'b0;
    cycles(1);
    coin5_raw = 1'b1;
    e0 = cyc + 1;
    cycles(10);
    coin5_raw = 1'b0;
    cycles(20);
    check("t2_ncoin", coin_cyc_q.size() - base, 1);
    if (coin_cyc_q.size() > base) begin
      check("t2_code", coin_val_q[base], 1);
      check("t2_latency", coin_cyc_q[base] - e0, 9);
    end

    // 3: 3-cycle glitch is rejected.
    base = coin_cyc_q.size();
    ret0 = n_ret;
    jam0 = n_jam;
    nz0  = n_fifo_nz;
    coin5_raw = 1'b1;
    cycles(3);
    coin5_raw = 1'b0;
    cycles(20);
    check("t3_ncoin", coin_cyc_q.size() - base, 0);
    check("t3_fifo_nz", n_fifo_nz - nz0, 0);
    check("t3_return", n_ret - ret0, 0);
    check("t3_jam", n_jam - jam0, 0);

    // 4: overflow with accept_en low, then drain.
    accept_en = 1'b0;
    ret0 = n_ret;
    jam0 = n_jam;
    for (int i = 0; i < 5; i++) begin
      insert5();
      check($sformatf("t4_count%0d", i), int'(fifo_count), (i < 4) ? i + 1 : 4);
    end
    check("t4_return", n_ret - ret0, 1);
    check("t4_jam", n_jam - jam0, 0);
    base = coin_cyc_q.size();
    accept_en = 1'b1;
    cycles(20);
    check("t4_ncoin", coin_cyc_q.size() - base, 4);
    for (int j = 0; j < 4; j++) begin
      if (coin_cyc_q.size() > base + j) begin
        check($sformatf("t4_code%0d", j), coin_val_q[base + j], 1);
        if (j > 0) begin
          check($sformatf("t4_space%0d", j),
                coin_cyc_q[base + j] - coin_cyc_q[base + j - 1], 3);
        end
      end
    end
    check("t4_final_count", int'(fifo_count), 0);

    // 5: simultaneous insertion is a jam.
    base = coin_cyc_q.size();
    ret0 = n_ret;
    jam0 = n_jam;
    nz0  = n_fifo_nz;
    coin5_raw  = 1'b1;
    coin10_raw = 1'b1;
    cycles(8);
    check("t5_e7_jam", int'(jam), 0);
    cycles(1);
    check("t5_e8_jam", int'(jam), 1);
    check("t5_e8_return", int'(coin_return), 1);
    cycles(1);
    check("t5_e9_jam", int'(jam), 0);
    coin5_raw  = 1'b0;
    coin10_raw = 1'b0;
    cycles(20);
    check("t5_njam", n_jam - jam0, 1);
    check("t5_nreturn", n_ret - ret0, 1);
    check("t5_misalign", n_misalign, 0);
    check("t5_ncoin", coin_cyc_q.size() - base, 0);
    check("t5_fifo_nz", n_fifo_nz - nz0, 0);

    // 6: asynchronous reset mid-gap with two coins still queued.
    accept_en = 1'b0;
    for (int i = 0; i < 3; i++) insert5();
    check("t6_count3", int'(fifo_count), 3);
    accept_en = 1'b1;
    cycles(1);
    check("t6_issue_coin", int'(coin), 1);
    check("t6_issue_count", int'(fifo_count), 2);
    cycles(1);
    check("t6_gap_coin", int'(coin), 0);
    check("t6_gap_count", int'(fifo_count), 2);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_count", int'(fifo_count), 0);
    check("t6_async_coin", int'(coin), 0);
    check("t6_async_return", int'(coin_return), 0);
    @(negedge clk);
    rst = 1'b1;
    base = coin_cyc_q.size();
    cycles(20);
    check("t6_post_ncoin", coin_cyc_q.size() - base, 0);
    check("t6_post_count", int'(fifo_count), 0);

    check("code_11_seen", n_bad_code, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
